// File: rtl/sqrt_pkg.sv
// Shared constants and FSM encoding for the sequential square-root unit.
package sqrt_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Odd-number accumulation: square tracks (root+1)^2, delta tracks 2*(root+1)+1.
  localparam int unsigned SQUARE_INIT = 1;
  localparam int unsigned DELTA_INIT  = 3;
  localparam int unsigned DELTA_STEP  = 2;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sqrt_datapath.sv
// Operand/square/delta/root registers with their adders and the square<=operand comparator.
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_operand,
  output logic                 o_le,
  output logic [WIDTH/2-1:0]   o_root
);

  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned DW = WIDTH / 2 + 2;
  localparam int unsigned RW = WIDTH / 2;

  logic [WIDTH-1:0] r_operand;
  logic [SW-1:0]    r_square;
  logic [DW-1:0]    r_delta;
  logic [RW-1:0]    r_root;

  logic [SW-1:0]    w_square_next;
  logic [DW-1:0]    w_delta_next;
  logic [RW-1:0]    w_root_next;

  assign w_square_next = r_square + SW'(r_delta);
  assign w_delta_next  = r_delta + DW'(DELTA_STEP);
  assign w_root_next   = r_root + RW'(1);

  // Square is one bit wider so (2^(WIDTH/2))^2 compares correctly against any operand.
  assign o_le   = (r_square <= {1'b0, r_operand});
  assign o_root = r_root;

  // Load initial values on i_load, advance one odd-number step on i_step, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_operand <= '0;
      r_square  <= '0;
      r_delta   <= '0;
      r_root    <= '0;
    end else if (i_load) begin
      r_operand <= i_operand;
      r_square  <= SW'(SQUARE_INIT);
      r_delta   <= DW'(DELTA_INIT);
      r_root    <= '0;
    end else if (i_step) begin
      r_square  <= w_square_next;
      r_delta   <= w_delta_next;
      r_root    <= w_root_next;
    end
  end

endmodule

// File: rtl/square_root_seq.sv
// Sequential floor(sqrt(valor_i)); each computation is started by reset release.
module square_root_seq
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   valor_i,
  output logic               ready_o,
  output logic [WIDTH/2-1:0] root_o
);

  state_t r_state;
  state_t w_state_next;
  logic   w_load;
  logic   w_step;
  logic   w_le;

  // State register; reset returns to INIT so the next release starts a computation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_next;
  end

  // Next-state and datapath enables.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      INIT: begin
        w_load       = 1'b1;
        w_state_next = CALC;
      end
      CALC: begin
        if (w_le) w_step       = 1'b1;
        else      w_state_next = DONE;
      end
      DONE:    w_state_next = DONE;
      default: w_state_next = INIT;
    endcase
  end

  // Busy flag decoded straight from the state register, so it only moves on clk or rst.
  assign ready_o = (r_state != DONE);

  sqrt_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_operand (valor_i),
    .o_le      (w_le),
    .o_root    (root_o)
  );

endmodule

// File: tb/tb_square_root_seq.sv
// Scoreboard bench for square_root_seq: stimulus pushes expected root/latency, monitor checks on ready_o fall.
module tb_square_root_seq;

  typedef struct {
    int root;
    int lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] valor_i = '0;
  logic        ready_o;
  logic [7:0]  root_o;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  square_root_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .valor_i (valor_i),
    .ready_o (ready_o),
    .root_o  (root_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: counts edges since reset release and scores each ready_o fall.
  initial begin
    int   cnt = 0;
    logic prev = 1'b1;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cnt  = 0;
        prev = 1'b1;
      end else begin
        cnt++;
        if (prev && !ready_o) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("root", int'(root_o), e.root);
            check("latency", cnt, e.lat);
          end
        end
        prev = ready_o;
      end
    end
  end

  task automatic pulse_reset(input logic [15:0] v);
    @(negedge clk);
    valor_i = v;
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(ready_o), 1);
    check("rst_root", int'(root_o), 0);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check(name, 0, 1);
      sb.delete();
    end
  endtask

  task automatic run_vec(input logic [15:0] v, input int r);
    exp_t e;
    pulse_reset(v);
    e.root = r;
    e.lat  = r + 2;
    sb.push_back(e);
    rst = 1'b0;
    wait_drain("timeout");
  endtask

  initial begin
    logic [15:0] vals [14] = '{16'd65535, 16'd0, 16'd1, 16'd3, 16'd4, 16'd15, 16'd16,
                               16'd255, 16'd256, 16'd65025, 16'd65024, 16'd50000,
                               16'd1000, 16'd12345};
    int roots [14] = '{255, 0, 1, 1, 2, 3, 4, 15, 16, 255, 254, 223, 31, 111};
    exp_t e;

    #1;
    check("init_ready", int'(ready_o), 1);
    check("init_root", int'(root_o), 0);

    for (int i = 0; i < 14; i++) run_vec(vals[i], roots[i]);

    // Abort mid-computation; reset must take effect without a clock edge.
    pulse_reset(16'd40000);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", int'(ready_o), 1);
    check("abort_root", int'(root_o), 0);
    @(negedge clk);
    e.root = 200;
    e.lat  = 202;
    sb.push_back(e);
    rst = 1'b0;
    wait_drain("abort_timeout");

    // Operand is latched at INIT; later input changes must not matter.
    pulse_reset(16'd100);
    e.root = 10;
    e.lat  = 12;
    sb.push_back(e);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    valor_i = 16'd9;
    wait_drain("latch_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_ready", int'(ready_o), 0);
      check("hold_root", int'(root_o), 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
